// File: rtl/sv_assoc_pkg.sv
// sv_assoc_pkg -- shared definitions for the sparse associative memory.
//   ADDR_W_DEF / DATA_W_DEF / DEPTH_DEF : default key width, data width, entry count
//   entry_t                             : one storage entry {valid, key, data}
// Entry fields are sized to the default (maximum) widths. Narrower instances
// zero-extend their keys and data into these fields.
package sv_assoc_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;
    localparam int DEPTH_DEF  = 16;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] key;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/sv_assoc_cam.sv
// sv_assoc_cam -- parallel key compare and free-entry priority encoder.
//   entries  : in  all storage entries
//   key      : in  lookup key, zero-extended to the entry key width
//   hit_vec  : out one-hot vector of valid entries whose key equals the lookup key
//   free_idx : out index of the lowest-numbered invalid entry (0 when full)
//   full     : out every entry is valid
// Purely combinational.
module sv_assoc_cam
    import sv_assoc_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  entry_t [DEPTH-1:0]    entries,
    input  logic [ADDR_W_DEF-1:0] key,
    output logic [DEPTH-1:0]      hit_vec,
    output logic [IDX_W-1:0]      free_idx,
    output logic                  full
);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        hit_vec  = '0;
        free_idx = '0;
        full     = 1'b1;
        // Scan from the top down so the lowest free index is the last one written.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hit_vec[i] = entries[i].valid && (entries[i].key == key);
            if (!entries[i].valid) begin
                free_idx = IDX_W'(i);
                full     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sv_assoc.sv
// sv_assoc -- sparse associative memory: DEPTH key/data pairs, unwritten keys read 0.
//   clk   : in  clock, all state updates on the rising edge
//   rst_n : in  synchronous reset, ACTIVE HIGH (name inherited from the codebase)
//   wen   : in  write request: update on hit, allocate lowest free entry on miss,
//               drop silently when full
//   ren   : in  read request: rdout shows the matched data (or 0) one edge later
//   wdin  : in  write data
//   addr  : in  key shared by read and write, full width compared
//   rdout : out registered read data, holds while ren=0
// A read and write in the same cycle return the pre-write value.
// ADDR_W and DATA_W may not exceed the package default widths.
module sv_assoc
    import sv_assoc_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic              ren,
    input  logic [DATA_W-1:0] wdin,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rdout
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t [DEPTH-1:0]    mem;
    logic [DEPTH-1:0]      hit_vec;
    logic [IDX_W-1:0]      free_idx;
    logic                  full;
    logic [ADDR_W_DEF-1:0] key_ext;
    logic [DATA_W_DEF-1:0] wdin_ext;
    logic [DATA_W-1:0]     rd_data;

    assign key_ext  = ADDR_W_DEF'(addr);
    assign wdin_ext = DATA_W_DEF'(wdin);

    sv_assoc_cam #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_cam (
        .entries  (mem),
        .key      (key_ext),
        .hit_vec  (hit_vec),
        .free_idx (free_idx),
        .full     (full)
    );

    // At most one hit, so OR-ing the selected entries gives the hit data or 0.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_vec[i]) begin
                rd_data = rd_data | mem[i].data[DATA_W-1:0];
            end
        end
    end

    // NOTE: non-blocking assignments mean rd_data is computed from the entries
    // before this edge's write lands, which gives read-before-write for free.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            // NOTE: only the valid bits are cleared; key/data of an invalid entry
            // are never observed, so resetting them would add reset fan-out to
            // the whole storage array for no benefit.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].valid <= 1'b0;
            end
            rdout <= '0;
        end else begin
            if (ren) begin
                rdout <= rd_data;
            end
            if (wen) begin
                if (|hit_vec) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (hit_vec[i]) begin
                            mem[i].data <= wdin_ext;
                        end
                    end
                end else if (!full) begin
                    mem[free_idx].valid <= 1'b1;
                    mem[free_idx].key   <= key_ext;
                    mem[free_idx].data  <= wdin_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_sv_assoc.sv
// tb_sv_assoc -- self-checking bench for sv_assoc.
// An associative-array reference model computes each read's expected value when
// the read is driven; the value is queued and compared once rdout updates.
module tb_sv_assoc;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic              clk;
    logic              rst_n;
    logic              wen;
    logic              ren;
    logic [DATA_W-1:0] wdin;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdout;

    sv_assoc #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (wen),
        .ren   (ren),
        .wdin  (wdin),
        .addr  (addr),
        .rdout (rdout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] last_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (model.exists(a)) model[a] = d;
        else if (model.num() < DEPTH) model[a] = d;
    endtask

    // One request cycle. Inputs change 1 time unit after the edge, rdout is
    // sampled at the same point, away from the sampling edge.
    task automatic op(input string tag, input logic w, input logic r,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] e;
        wen  = w;
        ren  = r;
        addr = a;
        wdin = d;
        if (r) exp_q.push_back(model.exists(a) ? model[a] : '0);
        if (w) model_write(a, d);
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
        if (r) begin
            e = exp_q.pop_front();
            check(tag, rdout, e);
            last_rd = e;
        end else begin
            check({tag, "_hold"}, rdout, last_rd);
        end
    endtask

    // One reset cycle with junk requests that must be ignored.
    task automatic do_reset(input string tag);
        rst_n = 1'b1;
        wen   = 1'b1;
        ren   = 1'b1;
        addr  = 64'h55;
        wdin  = 64'h1234;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        model.delete();
        exp_q.delete();
        last_rd = '0;
        check(tag, rdout, 64'h0);
    endtask

    initial begin
        rst_n = 1'b1;
        wen   = 1'b0;
        ren   = 1'b0;
        addr  = '0;
        wdin  = '0;
        last_rd = '0;
        @(posedge clk);
        #1;
        do_reset("reset_rdout");
        op("junk_in_reset", 1'b0, 1'b1, 64'h55, 64'h0);

        // Basic write then read, then an unwritten key.
        op("wr10", 1'b1, 1'b0, 64'h10, 64'hA5A5);
        op("rd10", 1'b0, 1'b1, 64'h10, 64'h0);
        op("idle", 1'b0, 1'b0, 64'h10, 64'h0);
        op("rd_unwritten", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0);

        // Rewrite of the same key consumes one entry only.
        do_reset("reset2");
        op("wr10a", 1'b1, 1'b0, 64'h10, 64'h1);
        op("wr10b", 1'b1, 1'b0, 64'h10, 64'h2);
        op("rd10_rewrite", 1'b0, 1'b1, 64'h10, 64'h0);
        for (int i = 0; i < DEPTH - 1; i++)
            op("fill15", 1'b1, 1'b0, 64'h200 + 64'(i), 64'hC00 + 64'(i));
        op("wr_over_full", 1'b1, 1'b0, 64'h300, 64'hDEAD);
        op("rd_last_fill", 1'b0, 1'b1, 64'h20E, 64'h0);
        op("rd_dropped", 1'b0, 1'b1, 64'h300, 64'h0);
        op("rd10_still", 1'b0, 1'b1, 64'h10, 64'h0);

        // Fill all entries, then a dropped write to a new key.
        do_reset("reset3");
        for (int i = 0; i < DEPTH; i++)
            op("fill16", 1'b1, 1'b0, 64'(i), 64'(i) + 64'h100);
        op("wr99_full", 1'b1, 1'b0, 64'h99, 64'h77);
        op("rd99_dropped", 1'b0, 1'b1, 64'h99, 64'h0);
        for (int i = 0; i < DEPTH; i++)
            op("rd_fill16", 1'b0, 1'b1, 64'(i), 64'h0);

        // Same-cycle read and write returns the old value.
        do_reset("reset4");
        op("wr20", 1'b1, 1'b0, 64'h20, 64'h5);
        op("rw20_old", 1'b1, 1'b1, 64'h20, 64'h6);
        op("idle2", 1'b0, 1'b0, 64'h0, 64'h0);
        op("rd20_new", 1'b0, 1'b1, 64'h20, 64'h0);
        op("rw_new_key", 1'b1, 1'b1, 64'h21, 64'h9);
        op("rd21", 1'b0, 1'b1, 64'h21, 64'h0);

        // Reset clears contents and rdout.
        op("wr30", 1'b1, 1'b0, 64'h30, 64'hBEEF);
        op("rd30", 1'b0, 1'b1, 64'h30, 64'h0);
        do_reset("reset_after_30");
        op("rd30_after_reset", 1'b0, 1'b1, 64'h30, 64'h0);
        op("rd55_ignored", 1'b0, 1'b1, 64'h55, 64'h0);

        // Random mix over a key pool larger than DEPTH so full is exercised.
        do_reset("reset_rand");
        for (int n = 0; n < 400; n++) begin
            logic [ADDR_W-1:0] a;
            a = 64'hF000_0000_0000_1000 + 64'($urandom_range(0, 23));
            op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
               {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
